// File: rtl/mem_region_controller.sv
// mem_region_controller: decodes CPU accesses into wait-stated memory regions, an I/O window and control registers
module mem_region_controller #(
    parameter int                  NREG      = 6,
    parameter logic [NREG*32-1:0]  REG_BASE  = {32'h9000_0000, 32'h8000_0000, 32'h1000_0000,
                                                32'h0000_2000, 32'h0000_0000, 32'h0040_0000},
    parameter logic [NREG*32-1:0]  REG_END   = {32'hFFFF_FFFF, 32'h8000_FFFF, 32'h1000_FFFF,
                                                32'h0000_7FFF, 32'h0000_3FFF, 32'h0040_FFFF},
    parameter logic [NREG*4-1:0]   REG_WAIT  = {4'd0, 4'd7, 4'd3, 4'd2, 4'd1, 4'd0},
    parameter int                  NCTRL     = 2,
    parameter logic [31:0]         CTRL_BASE = 32'hFFFF_0110,
    parameter logic [31:0]         CTRL_RST  = 32'h0,
    parameter logic [31:0]         IO_BASE   = 32'hFFFF_0000
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iReq,
    input  logic                iMemRead,
    input  logic                iMemWrite,
    input  logic [31:0]         iAddress,
    input  logic [3:0]          iByteEnable,
    input  logic [31:0]         iWriteData,
    output logic [31:0]         oMemData,
    output logic                oReady,
    output logic                oBusError,
    output logic [NREG-1:0]     oRegSel,
    output logic [29:0]         oRegAddr,
    output logic [3:0]          oRegByteEna,
    output logic [31:0]         oRegData,
    output logic                oRegWren,
    input  logic [NREG*32-1:0]  iRegQ,
    input  logic [31:0]         iIOData,
    output logic [NCTRL*32-1:0] oCtrl
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} stateT;

    stateT       state, nextState;
    logic        wrQ, firstCyc, isCtrl, isIo, isReg, accErr, accept;
    logic [2:0]  regIdx, hitIdx, ctrlIdx;
    logic [3:0]  waitCnt;
    logic [31:0] ctrlOff;

    // Address decode with priority ctrl > I/O > lowest-index matching region
    always_comb begin
        ctrlOff = iAddress - CTRL_BASE;
        ctrlIdx = ctrlOff[4:2];
        isCtrl  = (iAddress >= CTRL_BASE) && (ctrlOff < 32'(4 * NCTRL));
        isIo    = !isCtrl && (iAddress >= IO_BASE);
        isReg   = 1'b0;
        hitIdx  = 3'd0;
        for (int k = NREG - 1; k >= 0; k--)
            if (iAddress >= REG_BASE[k*32 +: 32] && iAddress <= REG_END[k*32 +: 32]) begin
                isReg  = 1'b1;
                hitIdx = 3'(k);
            end
        accErr = (iMemRead == iMemWrite) || (iAddress[1:0] != 2'b00) || !(isCtrl || isIo || isReg);
        accept = (state == IDLE) && iReq;
    end

    // State register; an asynchronous reset abandons any access in flight
    always_ff @(posedge iCLK or negedge iRST_n)
        if (!iRST_n) state <= IDLE;
        else         state <= nextState;

    // Next state and handshake/strobe outputs derived from the current state
    always_comb begin
        nextState = state;
        oReady    = (state == RESP) || (state == ERR);
        oBusError = (state == ERR);
        oRegWren  = (state == ACCESS) && firstCyc && wrQ;
        for (int k = 0; k < NREG; k++)
            oRegSel[k] = (state == ACCESS) && (regIdx == 3'(k));
        unique case (state)
            IDLE:    if (iReq) nextState = accErr ? ERR : (isCtrl || isIo) ? RESP : ACCESS;
            ACCESS:  if (waitCnt == 4'd0) nextState = RESP;
            default: nextState = IDLE;
        endcase
    end

    // Request latch, wait countdown, read-data capture and control register writes
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oMemData    <= '0;
            oRegAddr    <= '0;
            oRegByteEna <= '0;
            oRegData    <= '0;
            wrQ         <= 1'b0;
            regIdx      <= '0;
            waitCnt     <= '0;
            firstCyc    <= 1'b0;
            oCtrl       <= {NCTRL{CTRL_RST}};
        end else begin
            if (accept) begin
                oRegAddr    <= iAddress[31:2];
                oRegByteEna <= iByteEnable;
                oRegData    <= iWriteData;
                wrQ         <= iMemWrite;
                regIdx      <= hitIdx;
                waitCnt     <= REG_WAIT[{hitIdx, 2'd0} +: 4];
                firstCyc    <= 1'b1;
                if (!accErr && isCtrl && iMemWrite)
                    for (int b = 0; b < 4; b++)
                        if (iByteEnable[b]) oCtrl[{ctrlIdx, 2'(b), 3'd0} +: 8] <= iWriteData[b*8 +: 8];
                if (!accErr && iMemRead && (isCtrl || isIo))
                    oMemData <= isCtrl ? oCtrl[{ctrlIdx, 5'd0} +: 32] : iIOData;
            end
            if (state == ACCESS) begin
                firstCyc <= 1'b0;
                if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
                else if (!wrQ)       oMemData <= iRegQ[{regIdx, 5'd0} +: 32];
            end
        end
    end
endmodule
